// File: rtl/ram_burst_ctrl.sv
// Burst initiator for a 100-word synchronous RAM: range-checks a host command,
// then issues one write (stream-fed) or read (stream-returned) access per cycle.
module ram_burst_ctrl #(
    parameter int DEPTH = 100,
    parameter int AW    = 7,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          op,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rw,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          rd_pend_q, rd_pend_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic [AW:0]   end_addr;

    // One bit wider than the address so base+len cannot wrap.
    assign end_addr = {1'b0, base_addr} + {1'b0, len};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rd_pend_q <= rd_pend_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        rd_pend_d = 1'b0;
        rd_data_d = rd_pend_q ? mem_dout : rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    ptr_d = base_addr;
                    cnt_d = len;
                    if (len == '0) begin
                        state_d = S_DONE;
                    end else if (end_addr > DEPTH_W) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = op ? S_WRITE : S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (wr_valid) begin
                    ptr_d = ptr_q + AW'(1);
                    cnt_d = cnt_q - AW'(1);
                    if (cnt_q == AW'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                ptr_d     = ptr_q + AW'(1);
                cnt_d     = cnt_q - AW'(1);
                rd_pend_d = 1'b1;
                if (cnt_q == AW'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ready = 1'b0;
        mem_rw   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        err      = err_q;
        rd_valid = rd_pend_q;
        // The RAM output is already registered; pass it straight through on the
        // valid cycle and keep the last captured word otherwise.
        rd_data  = rd_pend_q ? mem_dout : rd_data_q;
        case (state_q)
            S_WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    mem_rw   = 1'b1;
                    mem_addr = ptr_q;
                    mem_din  = wr_data;
                end
            end
            S_READ:  mem_addr = ptr_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed table-driven bench for ram_burst_ctrl with a behavioural 128-entry
// registered-output RAM attached to the memory port.
module tb_ram_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [6:0]  base_addr;
    logic [6:0]  len;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        err;
    logic [6:0]  mem_addr;
    logic        mem_rw;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    always #5 clk = ~clk;

    ram_burst_ctrl #(.DEPTH(100), .AW(7), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .base_addr(base_addr), .len(len), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    logic [31:0] ram [0:127];
    always @(posedge clk) begin
        if (mem_rw) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    typedef struct {
        bit              op;
        int              base;
        int              len;
        logic [63:0]     vpat;
        bit              poke;
        logic [3:0][31:0] data;
        int              exp_done;
        bit              exp_err;
        int              exp_nwr;
        int              exp_nrv;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;

    int          wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] rd_q[$];
    int          first_rv;
    int          illegal_n;
    int          addr_nz_n;
    logic [3:0][31:0] cur_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_burst(input bit op_v, input int base_v, input int len_v,
                             input logic [63:0] vpat, input bit poke,
                             output int done_cyc, output logic err_done,
                             output logic err_after, output logic busy_after);
        int wr_idx;
        wr_idx = 0;
        wa_q.delete(); wd_q.delete(); rd_q.delete();
        first_rv = -1; illegal_n = 0; addr_nz_n = 0; done_cyc = -1;
        err_done = 1'bx;
        @(posedge clk); #1;
        start = 1'b1; op = op_v; base_addr = 7'(base_v); len = 7'(len_v); wr_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            wr_valid = (c <= 64) ? vpat[c-1] : 1'b1;
            wr_data  = (wr_idx < 4) ? cur_data[wr_idx] : 32'h0;
            if (poke && c == 2) begin
                start = 1'b1; op = ~op_v; base_addr = 7'd0; len = 7'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (mem_rw) begin
                wa_q.push_back(int'(mem_addr));
                wd_q.push_back(mem_din);
                wr_idx++;
            end
            if (rd_valid) begin
                if (first_rv < 0) first_rv = c;
                rd_q.push_back(rd_data);
            end
            if (mem_addr > 7'd99) illegal_n++;
            if (mem_addr != 7'd0) addr_nz_n++;
            if (done) begin
                done_cyc = c;
                err_done = err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        start = 1'b0; wr_valid = 1'b0;
        @(negedge clk);
        err_after  = err;
        busy_after = busy;
    endtask

    vec_t vecs [12];

    initial begin
        logic [3:0][31:0] d0, da, db, dc, dz;
        int          dcyc;
        logic        e_d, e_a, b_a;
        int          done_pulses;

        for (int i = 0; i < 128; i++) ram[i] = 32'h0;
        mem_dout = 32'h0;
        d0 = {32'h99AABBCC, 32'h55667788, 32'h11223344, 32'hAABBCCDD};
        da = {32'h0, 32'h03030303, 32'h02020202, 32'h01010101};
        db = {32'h0, 32'h0, 32'hCAFEF00D, 32'hDEADBEEF};
        dc = {32'h44440004, 32'h33330003, 32'h22220002, 32'h11110001};
        dz = '0;
        //            op    base len vpat      poke  data done err nwr nrv
        vecs[0]  = '{1'b1,   0,   4, '1,       1'b0, d0,  5, 1'b0, 4, 0};
        vecs[1]  = '{1'b0,   0,   4, '1,       1'b0, d0,  6, 1'b0, 0, 4};
        vecs[2]  = '{1'b1,  10,   3, 64'h15,   1'b0, da,  6, 1'b0, 3, 0};
        vecs[3]  = '{1'b0,  10,   3, '1,       1'b0, da,  5, 1'b0, 0, 3};
        vecs[4]  = '{1'b1,  98,   2, '1,       1'b0, db,  3, 1'b0, 2, 0};
        vecs[5]  = '{1'b0,  98,   2, '1,       1'b0, db,  4, 1'b0, 0, 2};
        vecs[6]  = '{1'b1,  99,   2, '1,       1'b0, dz,  1, 1'b1, 0, 0};
        vecs[7]  = '{1'b0,   0,   0, '1,       1'b0, dz,  1, 1'b0, 0, 0};
        vecs[8]  = '{1'b0, 100,   1, '1,       1'b0, dz,  1, 1'b1, 0, 0};
        vecs[9]  = '{1'b1,   1, 100, '1,       1'b0, dz,  1, 1'b1, 0, 0};
        vecs[10] = '{1'b1,  20,   4, '1,       1'b1, dc,  5, 1'b0, 4, 0};
        vecs[11] = '{1'b0,  20,   4, '1,       1'b0, dc,  6, 1'b0, 0, 4};

        rst_n = 1'b0; start = 1'b0; op = 1'b0; base_addr = '0; len = '0;
        wr_data = '0; wr_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", 64'({busy, done, err, rd_valid, wr_ready, mem_rw}), 64'h0);
        check("reset_addr", 64'(mem_addr), 64'h0);
        check("reset_din", 64'(mem_din), 64'h0);
        check("reset_rdata", 64'(rd_data), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int v = 0; v < 12; v++) begin
            cur_data = vecs[v].data;
            run_burst(vecs[v].op, vecs[v].base, vecs[v].len, vecs[v].vpat, vecs[v].poke,
                      dcyc, e_d, e_a, b_a);
            $display("vec %0d: op=%0d base=%0d len=%0d done_cyc=%0d err=%0d writes=%0d reads=%0d",
                     v, vecs[v].op, vecs[v].base, vecs[v].len, dcyc, e_d, wa_q.size(), rd_q.size());
            check($sformatf("v%0d_done_cycle", v), 64'(dcyc), 64'(vecs[v].exp_done));
            check($sformatf("v%0d_err_at_done", v), 64'(e_d), 64'(vecs[v].exp_err));
            check($sformatf("v%0d_err_held", v), 64'(e_a), 64'(vecs[v].exp_err));
            check($sformatf("v%0d_busy_after", v), 64'(b_a), 64'h0);
            check($sformatf("v%0d_nwrites", v), 64'(wa_q.size()), 64'(vecs[v].exp_nwr));
            check($sformatf("v%0d_nreads", v), 64'(rd_q.size()), 64'(vecs[v].exp_nrv));
            check($sformatf("v%0d_illegal_addr", v), 64'(illegal_n), 64'h0);
            for (int i = 0; i < vecs[v].exp_nwr && i < wa_q.size(); i++) begin
                check($sformatf("v%0d_waddr%0d", v, i), 64'(wa_q[i]), 64'(vecs[v].base + i));
                check($sformatf("v%0d_wdata%0d", v, i), 64'(wd_q[i]), 64'(vecs[v].data[i]));
            end
            for (int i = 0; i < vecs[v].exp_nrv && i < rd_q.size(); i++) begin
                check($sformatf("v%0d_rdata%0d", v, i), 64'(rd_q[i]), 64'(vecs[v].data[i]));
            end
            if (vecs[v].exp_nrv > 0) begin
                check($sformatf("v%0d_first_rvalid", v), 64'(first_rv), 64'd2);
            end
            if (vecs[v].exp_nwr == 0 && vecs[v].exp_nrv == 0) begin
                check($sformatf("v%0d_addr_idle", v), 64'(addr_nz_n), 64'h0);
            end
        end

        // Reset asserted in cycle 4 of a 10-word read.
        @(posedge clk); #1;
        start = 1'b1; op = 1'b0; base_addr = 7'd0; len = 7'd10;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_rdata_c2", 64'({rd_valid, rd_data}), {31'h0, 1'b1, 32'hAABBCCDD});
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_busy_c4", 64'(busy), 64'h1);
        @(posedge clk); #1;
        @(negedge clk);
        $display("reset mid-burst: busy=%0d done=%0d rd_valid=%0d mem_addr=%0d", busy, done, rd_valid, mem_addr);
        check("rst_mid_ctl", 64'({busy, done, err, rd_valid, wr_ready, mem_rw}), 64'h0);
        check("rst_mid_addr", 64'(mem_addr), 64'h0);
        check("rst_mid_din", 64'(mem_din), 64'h0);
        check("rst_mid_rdata", 64'(rd_data), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        done_pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy || mem_rw) done_pulses++;
        end
        check("rst_mid_no_done", 64'(done_pulses), 64'h0);

        cur_data = d0;
        run_burst(1'b0, 0, 1, '1, 1'b0, dcyc, e_d, e_a, b_a);
        $display("post-reset read: done_cyc=%0d words=%0d", dcyc, rd_q.size());
        check("post_rst_done_cycle", 64'(dcyc), 64'd3);
        check("post_rst_nreads", 64'(rd_q.size()), 64'd1);
        if (rd_q.size() > 0) check("post_rst_rdata", 64'(rd_q[0]), 64'hAABBCCDD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected $finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_burst_ctrl.md
# ram_burst_ctrl

Burst initiator for the 100-word synchronous `ram` block. It accepts a host command (base address, length, direction) and sequences one RAM access per cycle. Write data is pulled from a valid/ready stream; read data is returned as a valid-qualified stream. Out-of-range bursts are rejected before any RAM access. It sits between a host/test sequencer and the RAM macro, and drives the RAM's `addr`/`rw`/`din` pins and observes its `OUT`.

## Interface
- `DEPTH`, 100, number of RAM words; legal addresses are 0..DEPTH-1.
- `AW`, 7, address width.
- `DW`, 32, data width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: command strobe, sampled only in IDLE.
- `op` in 1: 1 = write burst, 0 = read burst; captured with `start`.
- `base_addr` in AW: first address; captured with `start`.
- `len` in AW: word count, 0..DEPTH; captured with `start`.
- `wr_data` in DW: write stream data.
- `wr_valid` in 1: write stream valid.
- `wr_ready` out 1: high in WRITE state.
- `rd_data` out DW: read stream data (registered).
- `rd_valid` out 1: one-cycle qualifier per read word; there is no backpressure.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: range-error status; valid from `done` until the next accepted `start`.
- `mem_addr` out AW: to RAM `addr`.
- `mem_rw` out 1: to RAM `rw`; 1 = write.
- `mem_din` out DW: to RAM `din`.
- `mem_dout` in DW: from RAM `OUT`. The RAM registers this output; it reflects the address sampled at the previous edge.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- **IDLE**
  - `start`=1 captures `op`, `base_addr`, `len`; clears `err`; sets `ptr`=`base_addr` and `cnt`=`len`.
  - `len`=0 goes to DONE with `err`=0 and issues no access.
  - `base_addr`+`len` > DEPTH goes to DONE with `err`=1 and issues no access. The sum is computed at AW+1 bits so it cannot wrap.
  - Otherwise goes to WRITE (`op`=1) or READ (`op`=0).
- **WRITE**
  - `wr_ready`=1.
  - When `wr_valid`=1, the block drives combinationally in the same cycle: `mem_rw`=1, `mem_addr`=`ptr`, `mem_din`=`wr_data`. It then increments `ptr` and decrements `cnt`.
  - When `wr_valid`=0, it drives `mem_rw`=0 (idle cycle) and holds `ptr`/`cnt`.
  - The handshake that makes `cnt` reach 0 moves the state to DONE.
- **READ**
  - Every cycle, unconditionally: `mem_rw`=0, `mem_addr`=`ptr`, then `ptr`++ and `cnt`--.
  - A flag is registered for each issued address. In the next cycle, `rd_data`<=`mem_dout` and `rd_valid`=1.
  - After the last issue, the state moves to DRAIN.
- **DRAIN**
  - Lasts one cycle; captures and presents the final word (`rd_valid`=1).
  - Then moves to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then IDLE.
- Outside WRITE and READ: `mem_rw`=0, `mem_addr`=0, `mem_din`=0. The controller never issues `mem_rw`=1 outside a WRITE handshake.
- `start` asserted while `busy`=1 is ignored. It is not queued.
- `ptr` never exceeds DEPTH-1 during access, guaranteed by the up-front range check. `mem_addr` never presents 100..127.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `rd_valid`=0, `rd_data`=0, `wr_ready`=0, `mem_rw`=0, `mem_addr`=0, `mem_din`=0; state IDLE, `ptr`=0, `cnt`=0.
- Reset asserted mid-burst:
  - Takes effect at the next edge and returns every output to its reset value.
  - Accesses already issued stand. No further access is issued.
  - `done` is not pulsed.
- Write burst of N words with `wr_valid` held high:
  - `start` is sampled at edge E0.
  - WRITE runs in cycles 1..N, one handshake per cycle.
  - `done` is asserted in cycle N+1.
  - Each `wr_valid`=0 cycle adds one cycle.
- Read burst of N words:
  - Addresses are issued in cycles 1..N.
  - `rd_valid` is high in cycles 2..N+1; cycle N+1 is DRAIN.
  - `done` is asserted in cycle N+2.
  - Read latency is 1 cycle from address issue to `rd_valid`.
- Rejected burst (error or `len`=0): `done` is asserted in cycle 1.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- `err` is valid while `done`=1 and holds until the next accepted `start`.

## Test plan
- Reset, then write `base_addr`=0, `len`=4, data 0xAABBCCDD, 0x11223344, 0x55667788, 0x99AABBCC. Expect 4 consecutive `mem_rw`=1 cycles at addresses 0..3, `done` in cycle 5, `err`=0.
- Read `base_addr`=0, `len`=4 after the write. Expect `rd_valid` in cycles 2..5 carrying the four words in order, `done` in cycle 6.
- Write `len`=3 with `wr_valid` toggling 1,0,1,0,1. Expect exactly 3 writes at consecutive addresses, `ptr` held during gaps, `done` one cycle after the third handshake.
- Range boundaries:
  - `base_addr`=98, `len`=2: accepted; addresses 98 and 99 accessed.
  - `base_addr`=99, `len`=2: `err`=1, `done` in cycle 1, no `mem_rw`=1, `mem_addr` stays 0.
  - `len`=0: `done` in cycle 1 with `err`=0.
- Read of `len`=10 with `rst_n` low in cycle 4:
  - All outputs return to reset values next edge; no `done` pulse.
  - A subsequent read of addr 0, `len`=1 returns 0xAABBCCDD.
- `start` pulsed during a busy burst: ignored. Access count and `done` timing are unchanged.
